// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pwm_fade_ctrl                                              |
// | Description : Fade controller for a PWM duty input. A command gives a     |
// |               target duty and a step period. The controller then walks   |
// |               the registered duty word toward the target, one step per   |
// |               (rate+1) clocks, and pulses done when the target is reached.|
// |               stop aborts a fade and freezes the duty where it is.       |
// | Options     : PWM_FADE_EXP_EN - exponential stepping instead of linear    |
// |               (up: (duty<<1)|1, down: duty>>1, clamped to the target).   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pwm_fade_ctrl #(
  parameter int DUTY_BITS = 8,
  parameter int RATE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DUTY_BITS-1:0] cmd_target,
  input  logic [RATE_BITS-1:0] cmd_rate,
  input  logic                 stop,
  output logic [DUTY_BITS-1:0] duty,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  localparam logic [RATE_BITS-1:0] c_rate_one = RATE_BITS'(1);
`ifndef PWM_FADE_EXP_EN
  localparam logic [DUTY_BITS-1:0] c_duty_one = DUTY_BITS'(1);
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DUTY_BITS-1:0] r_duty;
  logic [DUTY_BITS-1:0] w_duty_nxt;
  logic [DUTY_BITS-1:0] r_target;
  logic [DUTY_BITS-1:0] w_target_nxt;
  logic [RATE_BITS-1:0] r_rate;
  logic [RATE_BITS-1:0] w_rate_nxt;
  logic [RATE_BITS-1:0] r_presc;
  logic [RATE_BITS-1:0] w_presc_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_ready;
  logic                 w_accept;
  logic                 w_going_up;
  logic [DUTY_BITS-1:0] w_step;

  // A command is taken only in IDLE and only once reset has been released.
  assign w_accept   = cmd_valid && r_ready && (r_state == S_IDLE);
  assign w_going_up = (r_target > r_duty);

`ifdef PWM_FADE_EXP_EN
  logic [DUTY_BITS:0]   w_up_wide;
  logic [DUTY_BITS-1:0] w_dn;

  // Exponential step; the extra bit on the upward value catches overflow so
  // that any overshoot (or wrap) clamps to the target.
  always_comb begin
    w_up_wide = {r_duty, 1'b1};
    w_dn      = r_duty >> 1;
    w_step    = r_duty;
    if (w_going_up) begin
      if (w_up_wide > {1'b0, r_target}) begin
        w_step = r_target;
      end else begin
        w_step = w_up_wide[DUTY_BITS-1:0];
      end
    end else begin
      if (w_dn < r_target) begin
        w_step = r_target;
      end else begin
        w_step = w_dn;
      end
    end
  end
`else
  // Linear step of one LSB toward the target; it cannot overshoot because
  // the fade ends as soon as the target is reached.
  always_comb begin
    w_step = r_duty;
    if (w_going_up) begin
      w_step = r_duty + c_duty_one;
    end else begin
      w_step = r_duty - c_duty_one;
    end
  end
`endif

  // Next-state logic: command acceptance in IDLE, prescaled stepping in RAMP.
  always_comb begin
    w_state_nxt  = r_state;
    w_duty_nxt   = r_duty;
    w_target_nxt = r_target;
    w_rate_nxt   = r_rate;
    w_presc_nxt  = r_presc;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_target_nxt = cmd_target;
          w_rate_nxt   = cmd_rate;
          if (cmd_target == r_duty) begin
            // Nothing to fade: report completion right away.
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RAMP;
            w_presc_nxt = '0;
          end
        end
      end

      S_RAMP: begin
        if (stop) begin
          // Abort wins over a coincident step; duty stays frozen.
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
        end else if (r_presc == r_rate) begin
          w_presc_nxt = '0;
          w_duty_nxt  = w_step;
          if (w_step == r_target) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + c_rate_one;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_duty   <= '0;
      r_target <= '0;
      r_rate   <= '0;
      r_presc  <= '0;
      r_done   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_duty   <= w_duty_nxt;
      r_target <= w_target_nxt;
      r_rate   <= w_rate_nxt;
      r_presc  <= w_presc_nxt;
      r_done   <= w_done_nxt;
      r_ready  <= (w_state_nxt == S_IDLE);
    end
  end

  assign duty      = r_duty;
  assign busy      = (r_state == S_RAMP);
  assign done      = r_done;
  assign cmd_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pwm_fade_ctrl                                           |
// | Description : Directed, table-driven bench for pwm_fade_ctrl with        |
// |               hand-written sequences for the multi-cycle corner cases.   |
// |               Exponential checks are built when PWM_FADE_EXP_EN is set.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pwm_fade_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_target;
  logic [15:0] cmd_rate;
  logic        stop;
  logic [7:0]  duty;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  typedef struct {
    string       nm;
    logic        rn;
    logic        v;
    logic [7:0]  t;
    logic [15:0] r;
    logic        s;
    logic [7:0]  e_duty;
    logic        e_busy;
    logic        e_done;
    logic        e_ready;
  } vec_t;

  vec_t tbl[$];

  pwm_fade_ctrl #(
    .DUTY_BITS(8),
    .RATE_BITS(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_target(cmd_target),
    .cmd_rate  (cmd_rate),
    .stop      (stop),
    .duty      (duty),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input string nm, input logic rn, input logic v,
                              input logic [7:0] t, input logic [15:0] r,
                              input logic s, input logic [7:0] d, input logic b,
                              input logic dn, input logic rd);
    vec_t x;
    x.nm = nm; x.rn = rn; x.v = v; x.t = t; x.r = r; x.s = s;
    x.e_duty = d; x.e_busy = b; x.e_done = dn; x.e_ready = rd;
    return x;
  endfunction

  // Drive inputs, take one rising edge, then compare 1 time unit later.
  task automatic step_chk(input string nm, input logic rn, input logic v,
                          input logic [7:0] t, input logic [15:0] r,
                          input logic s, input logic [7:0] d, input logic b,
                          input logic dn, input logic rd);
    rst_n      = rn;
    cmd_valid  = v;
    cmd_target = t;
    cmd_rate   = r;
    stop       = s;
    @(posedge clk);
    #1;
    checks++;
    if ({duty, busy, done, cmd_ready} !== {d, b, dn, rd}) begin
      errors++;
      $display("FAIL %s: got duty=%0d busy=%0b done=%0b ready=%0b, want duty=%0d busy=%0b done=%0b ready=%0b",
               nm, duty, busy, done, cmd_ready, d, b, dn, rd);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = 8'd0;
    cmd_rate   = 16'd0;
    stop       = 1'b0;

    // name, rst_n, valid, target, rate, stop | duty, busy, done, ready
    tbl.push_back(mk("rst_a",    0, 0, 8'd0, 16'd0, 0, 8'd0, 0, 0, 0));
    tbl.push_back(mk("rst_b",    0, 1, 8'd9, 16'd0, 0, 8'd0, 0, 0, 0));
    tbl.push_back(mk("rst_rel",  1, 0, 8'd0, 16'd0, 0, 8'd0, 0, 0, 1));
`ifndef PWM_FADE_EXP_EN
    tbl.push_back(mk("acc5",     1, 1, 8'd5, 16'd0, 0, 8'd0, 1, 0, 0));
    tbl.push_back(mk("up1",      1, 0, 8'd0, 16'd0, 0, 8'd1, 1, 0, 0));
    tbl.push_back(mk("up2",      1, 0, 8'd0, 16'd0, 0, 8'd2, 1, 0, 0));
    tbl.push_back(mk("up3",      1, 0, 8'd0, 16'd0, 0, 8'd3, 1, 0, 0));
    tbl.push_back(mk("up4",      1, 0, 8'd0, 16'd0, 0, 8'd4, 1, 0, 0));
    tbl.push_back(mk("up5_done", 1, 0, 8'd0, 16'd0, 0, 8'd5, 0, 1, 1));
    tbl.push_back(mk("hold5",    1, 0, 8'd0, 16'd0, 0, 8'd5, 0, 0, 1));
    tbl.push_back(mk("same5",    1, 1, 8'd5, 16'd7, 0, 8'd5, 0, 1, 1));
    tbl.push_back(mk("same5_end",1, 0, 8'd0, 16'd0, 0, 8'd5, 0, 0, 1));
    tbl.push_back(mk("stop_idle",1, 0, 8'd0, 16'd0, 1, 8'd5, 0, 0, 1));
`endif

    foreach (tbl[i]) begin
      step_chk(tbl[i].nm, tbl[i].rn, tbl[i].v, tbl[i].t, tbl[i].r, tbl[i].s,
               tbl[i].e_duty, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_ready);
    end

`ifndef PWM_FADE_EXP_EN
    // 5 -> 2 at rate 3: a step every 4 clocks, the first 4 clocks after accept.
    step_chk("dn_acc", 1, 1, 8'd2, 16'd3, 0, 8'd5, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      step_chk("dn_ramp", 1, 0, 8'd0, 16'd0, 0, 8'(5 - k / 4),
               (k < 12), (k == 12), (k == 12));
    end

    // 2 -> 9 at rate 1, stopped exactly when the step past 7 is due.
    step_chk("st_acc", 1, 1, 8'd9, 16'd1, 0, 8'd2, 1, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      step_chk("st_ramp", 1, 0, 8'd0, 16'd0, 0, 8'(2 + k / 2), 1, 0, 0);
    end
    step_chk("st_stop",  1, 0, 8'd0, 16'd0, 1, 8'd7, 0, 0, 1);
    step_chk("st_after", 1, 0, 8'd0, 16'd0, 0, 8'd7, 0, 0, 1);

    // stop together with a command in IDLE: the command still goes through.
    step_chk("st_cmd",   1, 1, 8'd9, 16'd0, 1, 8'd7, 1, 0, 0);
    step_chk("st_cmd8",  1, 0, 8'd0, 16'd0, 0, 8'd8, 1, 0, 0);
    step_chk("st_cmd9",  1, 0, 8'd0, 16'd0, 0, 8'd9, 0, 1, 1);

    // Reset dropped mid-fade at duty 9: everything clears, no done.
    step_chk("mr_acc",   1, 1, 8'd15, 16'd0, 0, 8'd9, 1, 0, 0);
    step_chk("mr_rst",   0, 0, 8'd0,  16'd0, 0, 8'd0, 0, 0, 0);
    step_chk("mr_rel",   1, 0, 8'd0,  16'd0, 0, 8'd0, 0, 0, 1);
`else
    begin
      logic [7:0] up_seq [0:7];
      logic [7:0] dn_seq [0:7];
      up_seq = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63, 8'd127, 8'd200};
      dn_seq = '{8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1, 8'd0};
      step_chk("ex_up_acc", 1, 1, 8'd200, 16'd0, 0, 8'd0, 1, 0, 0);
      for (int k = 0; k < 8; k++) begin
        step_chk("ex_up", 1, 0, 8'd0, 16'd0, 0, up_seq[k],
                 (k < 7), (k == 7), (k == 7));
      end
      step_chk("ex_dn_acc", 1, 1, 8'd0, 16'd0, 0, 8'd200, 1, 0, 0);
      for (int k = 0; k < 8; k++) begin
        step_chk("ex_dn", 1, 0, 8'd0, 16'd0, 0, dn_seq[k],
                 (k < 7), (k == 7), (k == 7));
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter DUTY_BITS, default 8: width of the duty word driven to the PWM block.
REQ-002 Parameter RATE_BITS, default 16: width of the step-period prescaler.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  fade command present.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_target  input  DUTY_BITS  final duty for the fade.
REQ-008 cmd_rate  input  RATE_BITS  clk cycles per step, minus one.
REQ-009 stop  input  1  abort the current fade, freezing duty.
REQ-010 duty  output  DUTY_BITS  registered duty word to the PWM duty input.
REQ-011 busy  output  1  high while in RAMP.
REQ-012 done  output  1  one-cycle pulse when a fade reaches its target.

Function
REQ-013 The controller SHALL have two states: IDLE and RAMP.
REQ-014 cmd_ready SHALL be 1 in IDLE and 0 in RAMP and during reset.
REQ-015 A command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1; target and rate are latched on that edge.
REQ-016 If an accepted target equals the current duty, the controller SHALL stay in IDLE and pulse done on the next cycle.
REQ-017 Otherwise the controller SHALL enter RAMP with the prescaler cleared to 0.
REQ-018 In RAMP the prescaler SHALL increment each cycle; when it equals the latched rate, it wraps to 0 and duty takes one step toward the target.
REQ-019 The first step SHALL occur rate+1 cycles after acceptance; rate=0 steps every cycle.
REQ-020 Linear step: duty SHALL move by +1 or -1 toward the target.
REQ-021 When a step makes duty equal the target, the state SHALL return to IDLE on the same edge and done SHALL be 1 for exactly the following cycle.
REQ-022 busy SHALL equal (state==RAMP).
REQ-023 While stop=1 in RAMP, the state SHALL return to IDLE with duty held, no step taken and no done pulse.
REQ-024 If stop and a step coincide, stop SHALL win.
REQ-025 stop in IDLE SHALL have no effect.
REQ-026 If stop=1 and cmd_valid=1 in IDLE, the command SHALL be accepted.
REQ-027 duty SHALL never wrap: it stays within [min(start,target), max(start,target)].
REQ-028 In IDLE, duty SHALL hold its value indefinitely.

Reset
REQ-029 While rst_n=0 at a clock edge: state=IDLE, duty=0, prescaler=0, busy=0, done=0, cmd_ready=0.
REQ-030 cmd_ready SHALL rise on the first cycle after rst_n returns to 1.
REQ-031 Reset asserted mid-RAMP SHALL abandon the fade without a done pulse.

Configuration
REQ-032 With macro PWM_FADE_EXP_EN defined, upward steps SHALL be duty<=(duty<<1)|1 and downward steps duty<=duty>>1.
REQ-033 In exponential mode, any step that would pass or overflow beyond the target SHALL clamp duty to the target.
REQ-034 Without PWM_FADE_EXP_EN, only the linear +/-1 step SHALL be compiled.

Verification
REQ-035 Reset, then target=5 with rate=0: duty goes 1,2,3,4,5 on consecutive cycles; done pulses once; busy is high for 5 cycles.
REQ-036 From duty=5, target=2 with rate=3: duty decrements every 4 cycles with the first step 4 cycles after acceptance; done follows duty=2.
REQ-037 Target equal to current duty (3->3): no busy, done pulses on the next cycle, cmd_ready stays 1.
REQ-038 stop asserted on the same cycle as a scheduled step at duty=7: duty stays 7, state is IDLE, no done pulse, cmd_ready is 1 on the next cycle.
REQ-039 PWM_FADE_EXP_EN, DUTY_BITS=8, 0->200 at rate=0: duty goes 1,3,7,15,31,63,127,200; then 200->0 goes 100,50,25,12,6,3,1,0.
REQ-040 rst_n dropped mid-RAMP at duty=9: the next cycle shows duty=0, busy=0, done=0, cmd_ready=0.
